updown_mod_counter: RTL and testbench
=====================================

Name: updown_mod_counter

Overview:
- Parametrised successor to the team's basic binary counter.
- Adds direction control, programmable step, runtime modulus (MAX), parallel load, wrap or saturate mode, terminal-count, event pulse and sticky overflow flag.
- Single clock domain. Used as the general timing/index counter in datapath and control blocks.

Parameters:
- DWIDTH, 8, width of count value, D, STEP and MAX (legal range 2..32).

Ports:
- CLK    input   1        system clock, all state on rising edge
- RST    input   1        synchronous reset, active-low
- CE     input   1        clock enable; nothing except RST acts when CE=0
- SCLR   input   1        synchronous clear, qualified by CE
- LOAD   input   1        parallel load of D, qualified by CE
- D      input   DWIDTH   load value
- UP     input   1        1 = count up, 0 = count down
- STEP   input   DWIDTH   increment/decrement amount
- MAX    input   DWIDTH   inclusive upper bound; count range is 0..MAX
- SAT    input   1        1 = saturate at bounds, 0 = wrap modulo MAX+1
- Q      output  DWIDTH   registered count value
- TC     output  1        terminal count, combinational from Q, UP, MAX
- WRAP   output  1        registered one-cycle pulse: the previous cycle's count crossed or clipped a bound
- OVF    output  1        sticky flag, set by any bound event

Behaviour:
- Reset (RST=0 at a rising edge): Q=0, WRAP=0, OVF=0. RST overrides everything, including CE, SCLR and LOAD.
- CE=0:
  - Q and OVF hold.
  - WRAP goes 0 on the next edge, so it is always a single-cycle pulse.
- CE=1, priority SCLR > LOAD > count:
  - SCLR=1: Q=0, OVF=0, WRAP=0.
  - LOAD=1: Q = min(D, MAX), WRAP=0, OVF unchanged.
  - Otherwise, count one step (rules below).
- Effective step S = min(STEP, MAX). STEP=0 gives S=0, so Q holds with no event.
- Arithmetic:
  - Performed in DWIDTH+1 bits; no intermediate truncation.
  - M1 = MAX+1 is held in DWIDTH+1 bits.
- Up count (UP=1):
  - If Q+S <= MAX: Q = Q+S, no event.
  - Else, wrap mode: Q = Q+S-M1. Saturate mode: Q = MAX. Event in both modes.
- Down count (UP=0):
  - If Q >= S: Q = Q-S, no event.
  - Else, wrap mode: Q = Q+M1-S. Saturate mode: Q = 0. Event in both modes.
- Saturated hold:
  - In SAT=1, counting up while Q==MAX with S>0 keeps Q at MAX.
  - This counts as an event every such cycle, so WRAP stays high while pinned.
  - The same applies down at 0.
- Out-of-range Q (MAX lowered below the current Q):
  - On the next count cycle Q = 0 if SAT=0 or UP=0; Q = MAX if SAT=1 and UP=1.
  - Event flagged.
  - LOAD and SCLR behave normally.
- MAX=0: S=0, Q stays 0, and there are never any events.
- Event:
  - WRAP=1 on the following cycle only.
  - OVF set to 1, and stays set until SCLR (with CE) or reset.
- TC = (UP & Q==MAX) | (~UP & Q==0).
  - Combinational, no latency.
  - Valid regardless of CE.
- Latency: Q, WRAP and OVF change exactly one edge after the qualifying inputs are sampled.
- All inputs are sampled only at the rising edge of CLK. Mode, direction and MAX changes take effect on the next counting edge.

Test Plan:
- Reset: drive RST=0 mid-count with Q=0x37 and OVF=1, CE=1, LOAD=1 -> next edge Q=0, WRAP=0, OVF=0. The synchronous release is checked: no change before the edge.
- Wrap up: DWIDTH=8, MAX=9, STEP=3, UP=1, SAT=0, CE=1 from Q=0 -> Q 3,6,9,2,5,8,1. WRAP pulses for one cycle after the 9->2 and 8->1 edges. OVF=1 after the first wrap. TC=1 only while Q=9.
- Saturate down: MAX=200, load D=5, STEP=2, UP=0, SAT=1 -> Q 5,3,1,0,0. WRAP is high for the cycles following the 1->0 and 0->0 steps. TC=1 at Q=0.
- Priority and enables:
  - CE=0 with SCLR=1, LOAD=1 -> Q, OVF hold.
  - CE=1, SCLR=1, LOAD=1, D=7 -> Q=0, OVF=0.
  - CE=1, LOAD=1, D=250, MAX=100 -> Q=100.
- Boundary cases:
  - STEP=0 -> Q holds, no WRAP.
  - STEP=255 with MAX=9 -> S=9, so from Q=4 up wrap gives Q=3.
  - MAX=0 -> Q stays 0, no WRAP.
  - DWIDTH=8, MAX=255, Q=250, STEP=10, wrap -> Q=4, no truncation error.
- MAX lowered: Q=50, set MAX=20, UP=1 -> SAT=0 gives Q=0, SAT=1 gives Q=20. WRAP is pulsed and OVF is set in both cases.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with programmable step, runtime modulus, parallel load,
// wrap or saturate at the bounds, terminal count, one-cycle bound-event pulse and sticky overflow.
module updown_mod_counter #(
   parameter int DWIDTH = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CE,
   input  logic              SCLR,
   input  logic              LOAD,
   input  logic [DWIDTH-1:0] D,
   input  logic              UP,
   input  logic [DWIDTH-1:0] STEP,
   input  logic [DWIDTH-1:0] MAX,
   input  logic              SAT,
   output logic [DWIDTH-1:0] Q,
   output logic              TC,
   output logic              WRAP,
   output logic              OVF
);

   localparam logic [DWIDTH:0] ONE = {{DWIDTH{1'b0}}, 1'b1};

   logic [DWIDTH-1:0] load_val;
   logic [DWIDTH:0]   cnt_nxt;

   // Returns {event, next count}; all bound arithmetic is done one bit wider than Q.
   function automatic logic [DWIDTH:0] next_count(
      input logic [DWIDTH-1:0] q,
      input logic [DWIDTH-1:0] max,
      input logic [DWIDTH-1:0] step,
      input logic              up,
      input logic              sat
   );
      logic [DWIDTH-1:0] s;
      logic [DWIDTH:0]   q1;
      logic [DWIDTH:0]   s1;
      logic [DWIDTH:0]   m1;
      logic [DWIDTH:0]   r;
      logic              evt;
      s   = (step > max) ? max : step;
      q1  = {1'b0, q};
      s1  = {1'b0, s};
      m1  = {1'b0, max} + ONE;
      evt = 1'b0;
      r   = q1;
      if (q > max) begin
         // Modulus dropped below the current count: re-enter the range at a bound.
         evt = 1'b1;
         r   = (sat && up) ? {1'b0, max} : '0;
      end else if (up) begin
         r = q1 + s1;
         if (r > {1'b0, max}) begin
            evt = 1'b1;
            r   = sat ? {1'b0, max} : (r - m1);
         end
      end else begin
         if (q1 >= s1) begin
            r = q1 - s1;
         end else begin
            evt = 1'b1;
            r   = sat ? '0 : (q1 + m1 - s1);
         end
      end
      return {evt, r[DWIDTH-1:0]};
   endfunction

   assign load_val = (D > MAX) ? MAX : D;
   assign cnt_nxt  = next_count(Q, MAX, STEP, UP, SAT);
   assign TC       = (UP && (Q == MAX)) || (!UP && (Q == '0));

   always_ff @(posedge CLK) begin
      if (!RST) begin
         Q    <= '0;
         WRAP <= 1'b0;
         OVF  <= 1'b0;
      end else begin
         WRAP <= 1'b0;
         if (CE) begin
            if (SCLR) begin
               Q   <= '0;
               OVF <= 1'b0;
            end else if (LOAD) begin
               Q <= load_val;
            end else begin
               Q    <= cnt_nxt[DWIDTH-1:0];
               WRAP <= cnt_nxt[DWIDTH];
               if (cnt_nxt[DWIDTH]) begin
                  OVF <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: a behavioural model pushes expected state to a
// scoreboard each edge, and immediate assertions compare it against the DUT after the edge.
module tb_updown_mod_counter;

   localparam int DW = 8;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          CE = 1'b0;
   logic          SCLR = 1'b0;
   logic          LOAD = 1'b0;
   logic [DW-1:0] D = '0;
   logic          UP = 1'b1;
   logic [DW-1:0] STEP = '0;
   logic [DW-1:0] MAX = '0;
   logic          SAT = 1'b0;
   logic [DW-1:0] Q;
   logic          TC;
   logic          WRAP;
   logic          OVF;

   typedef struct {
      logic [DW-1:0] q;
      logic          w;
      logic          o;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   mq = 0;
   logic mw = 1'b0;
   logic mo = 1'b0;

   updown_mod_counter #(.DWIDTH(DW)) dut (
      .CLK (CLK),
      .RST (RST),
      .CE  (CE),
      .SCLR(SCLR),
      .LOAD(LOAD),
      .D   (D),
      .UP  (UP),
      .STEP(STEP),
      .MAX (MAX),
      .SAT (SAT),
      .Q   (Q),
      .TC  (TC),
      .WRAP(WRAP),
      .OVF (OVF)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model of one rising edge, written in plain integer arithmetic.
   task automatic model_edge();
      int s;
      int mx;
      mx = int'(MAX);
      s  = (int'(STEP) > mx) ? mx : int'(STEP);
      if (!RST) begin
         mq = 0; mw = 1'b0; mo = 1'b0;
      end else begin
         mw = 1'b0;
         if (CE) begin
            if (SCLR) begin
               mq = 0; mo = 1'b0;
            end else if (LOAD) begin
               mq = (int'(D) > mx) ? mx : int'(D);
            end else if (mq > mx) begin
               mq = (SAT && UP) ? mx : 0;
               mw = 1'b1;
            end else if (UP) begin
               if (mq + s <= mx) mq = mq + s;
               else begin
                  mw = 1'b1;
                  mq = SAT ? mx : mq + s - (mx + 1);
               end
            end else begin
               if (mq >= s) mq = mq - s;
               else begin
                  mw = 1'b1;
                  mq = SAT ? 0 : mq + (mx + 1) - s;
               end
            end
            if (mw) mo = 1'b1;
         end
      end
   endtask

   // One clock: model the edge, queue the expectation, then compare after the edge.
   task automatic step(input string tag);
      exp_t e;
      exp_t got;
      logic etc;
      model_edge();
      e.q = DW'(mq); e.w = mw; e.o = mo;
      sb.push_back(e);
      @(posedge CLK);
      #1;
      got = sb.pop_front();
      etc = (UP && (got.q == MAX)) || (!UP && (got.q == '0));
      chk({tag, ".Q"},    32'(Q),    32'(got.q));
      chk({tag, ".WRAP"}, 32'(WRAP), 32'(got.w));
      chk({tag, ".OVF"},  32'(OVF),  32'(got.o));
      chk({tag, ".TC"},   32'(TC),   32'(etc));
   endtask

   int wrap_seq[7] = '{3, 6, 9, 2, 5, 8, 1};
   int wrap_pls[7] = '{0, 0, 0, 1, 0, 0, 1};
   int sat_seq[4]  = '{3, 1, 0, 0};

   initial begin
      // Reset state
      RST = 1'b0; CE = 1'b1;
      step("reset0");
      chk("reset0.Qconst", 32'(Q), 32'd0);
      RST = 1'b1;

      // Wrap up, MAX=9 STEP=3
      MAX = 8'd9; STEP = 8'd3; UP = 1'b1; SAT = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step("wrapup");
         chk("wrapup.seq", 32'(Q), 32'(wrap_seq[i]));
         chk("wrapup.pulse", 32'(WRAP), 32'(wrap_pls[i]));
      end
      chk("wrapup.ovf", 32'(OVF), 32'd1);

      // Reset mid-count with Q=0x37, OVF=1, LOAD and CE active
      MAX = 8'd255; LOAD = 1'b1; D = 8'h37;
      step("load37");
      RST = 1'b0;
      #1;
      chk("rst.preedge.Q", 32'(Q), 32'h37);
      chk("rst.preedge.OVF", 32'(OVF), 32'd1);
      step("rst");
      chk("rst.Qconst", 32'(Q), 32'd0);
      RST = 1'b1; LOAD = 1'b0;

      // Saturate down from 5
      MAX = 8'd200; LOAD = 1'b1; D = 8'd5;
      step("satload");
      LOAD = 1'b0; STEP = 8'd2; UP = 1'b0; SAT = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step("satdown");
         chk("satdown.seq", 32'(Q), 32'(sat_seq[i]));
      end
      chk("satdown.pinned", 32'(WRAP), 32'd1);
      chk("satdown.tc", 32'(TC), 32'd1);

      // Priority and enables
      CE = 1'b0; SCLR = 1'b1; LOAD = 1'b1; D = 8'd7;
      step("ce0");
      chk("ce0.wrapdrop", 32'(WRAP), 32'd0);
      CE = 1'b1;
      step("sclr");
      SCLR = 1'b0; D = 8'd250; MAX = 8'd100;
      step("loadclip");
      chk("loadclip.Qconst", 32'(Q), 32'd100);
      LOAD = 1'b0;

      // STEP=0 holds
      STEP = 8'd0; UP = 1'b1; SAT = 1'b0;
      step("step0a");
      step("step0b");

      // STEP above MAX is clipped to MAX
      MAX = 8'd9; LOAD = 1'b1; D = 8'd4;
      step("ld4");
      LOAD = 1'b0; STEP = 8'd255;
      step("bigstep");
      chk("bigstep.Qconst", 32'(Q), 32'd3);

      // MAX=0 never counts or flags
      SCLR = 1'b1;
      step("clr0");
      SCLR = 1'b0; MAX = 8'd0; STEP = 8'd5;
      step("max0up");
      UP = 1'b0;
      step("max0dn");
      chk("max0.wrap", 32'(WRAP), 32'd0);

      // Full-range wrap without truncation
      UP = 1'b1; MAX = 8'd255; LOAD = 1'b1; D = 8'd250;
      step("ld250");
      LOAD = 1'b0; STEP = 8'd10;
      step("fullwrap");
      chk("fullwrap.Qconst", 32'(Q), 32'd4);

      // MAX lowered below Q, wrap then saturate
      SCLR = 1'b1;
      step("clr1");
      SCLR = 1'b0; LOAD = 1'b1; D = 8'd50;
      step("ld50a");
      LOAD = 1'b0; MAX = 8'd20; STEP = 8'd1;
      step("lowerwrap");
      chk("lowerwrap.Qconst", 32'(Q), 32'd0);
      SCLR = 1'b1;
      step("clr2");
      SCLR = 1'b0; MAX = 8'd255; LOAD = 1'b1;
      step("ld50b");
      LOAD = 1'b0; MAX = 8'd20; SAT = 1'b1;
      step("lowersat");
      chk("lowersat.Qconst", 32'(Q), 32'd20);
      chk("lowersat.ovf", 32'(OVF), 32'd1);

      // Short mixed run against the model
      SAT = 1'b0; MAX = 8'd13;
      for (int i = 0; i < 20; i++) begin
         UP   = 1'($urandom_range(1));
         SAT  = 1'($urandom_range(1));
         STEP = 8'($urandom_range(15));
         CE   = ($urandom_range(7) != 0);
         step("mixed");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
